// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the per-bank TCDM round-robin arbiter.
// Optional build macro used by the arbiter: TCDM_ARB_PERF_EN.
package tcdm_arb_pkg;

  localparam int unsigned CONFLICT_CNT_W = 32;

  // Response-pipeline index field is sized for the largest supported master count.
  localparam int unsigned RESP_IDX_W = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [RESP_IDX_W-1:0] idx;
    logic                  vld;
  } resp_entry_t;

endpackage

// File: rtl/tcdm_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// Used by tcdm_bank_rr_arb (whose optional feature macro is TCDM_ARB_PERF_EN).
module tcdm_rr_pick #(
  parameter int unsigned NumMaster = 8,
  parameter int unsigned IdxW      = 3
) (
  input  logic [NumMaster-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [IdxW-1:0]      idx_o,
  output logic                 valid_o
);

  logic        found;
  int unsigned cand;

  assign valid_o = |req_i;

  always_comb begin
    idx_o = ptr_i;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NumMaster; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NumMaster) cand = cand - NumMaster;
      if (!found && req_i[cand]) begin
        idx_o = IdxW'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_rr_arb.sv
// Per-bank round-robin arbiter: forwards the winning master to the bank and routes
// responses back after RespLat cycles. Macro TCDM_ARB_PERF_EN enables the conflict counter.
module tcdm_bank_rr_arb
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NumMaster     = 8,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter bit          WriteRespOn   = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumMaster-1:0]                    req_i,
  input  logic [NumMaster-1:0]                    wen_i,
  input  logic [NumMaster-1:0][ReqDataWidth-1:0]  data_i,
  output logic [NumMaster-1:0]                    gnt_o,
  output logic [NumMaster-1:0]                    vld_o,
  output logic [RespDataWidth-1:0]                rdata_o,
  output logic                                    req_o,
  output logic                                    wen_o,
  output logic [ReqDataWidth-1:0]                 data_o,
  input  logic                                    gnt_i,
  input  logic [RespDataWidth-1:0]                rdata_i,
  output logic [CONFLICT_CNT_W-1:0]               conflict_cnt_o
);

  localparam int unsigned IdxW = idx_width(NumMaster);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] winner;
  logic            any_req;
  logic            accept;
  resp_entry_t     stage0_d;
  resp_entry_t     pipe_q [RespLat];

  tcdm_rr_pick #(
    .NumMaster (NumMaster),
    .IdxW      (IdxW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (winner),
    .valid_o (any_req)
  );

  assign req_o   = any_req;
  assign accept  = any_req & gnt_i;
  assign wen_o   = wen_i[winner];
  assign data_o  = data_i[winner];
  assign rdata_o = rdata_i;

  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = accept;
  end

  // Fairness only advances on an accepted transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (winner == IdxW'(NumMaster - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_comb begin
    stage0_d.idx = RESP_IDX_W'(winner);
    stage0_d.vld = accept & (~wen_o | WriteRespOn);
  end

  // Stage boundary: pointer register and RespLat-deep response shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int s = 0; s < int'(RespLat); s++) pipe_q[s] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pipe_q[0] <= stage0_d;
      for (int s = 1; s < int'(RespLat); s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  always_comb begin
    vld_o = '0;
    for (int unsigned m = 0; m < NumMaster; m++) begin
      vld_o[m] = pipe_q[RespLat-1].vld && (pipe_q[RespLat-1].idx == RESP_IDX_W'(m));
    end
  end

`ifdef TCDM_ARB_PERF_EN
  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CONFLICT_CNT_W-1:0] cnt_q, cnt_d;
  logic                      conflict;

  // Two or more set bits <=> clearing the lowest set bit leaves something.
  assign conflict = |(req_i & (req_i - 1'b1));
  assign cnt_d    = conflict ? sat_inc(cnt_q) : cnt_q;

  // Stage boundary: conflict counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign conflict_cnt_o = cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule
